// File: rtl/prime_pkg.sv
// Shared types and constants for the prime enumerator and its remainder unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prime_pkg;

    // Candidate/limit width and prime-count width (54 primes <= 255 fit in 6 bits)
    localparam int WIDTH = 8;
    localparam int CNT_W = 6;

    // Largest representable candidate; the enumerator stops here instead of wrapping
    localparam logic [WIDTH-1:0] MAX_CAND = {WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        TEST,
        EMIT,
        FIN
    } state_t;

endpackage

// File: rtl/prime_rem.sv
// Restoring remainder unit: rem = dividend % divisor, one quotient bit per cycle.
// Latency: DW+1 cycles from go to the one-cycle rdy pulse; operands latched on go.
// Backpressure: none; go is ignored while an operation is in flight.
module prime_rem
    import prime_pkg::*;
#(
    parameter int DW = WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          rdy,
    output logic [DW-1:0] rem
);

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] q_sh;
    logic [DW-1:0] d_q;
    logic [DW-1:0] acc;
    logic [CW-1:0] iter;
    logic          running;
    logic [DW:0]   shifted;
    logic [DW:0]   diff;
    logic [DW-1:0] acc_n;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        shifted = {acc, q_sh[DW-1]};
        diff    = shifted - {1'b0, d_q};
        acc_n   = shifted[DW-1:0];
        if (shifted >= {1'b0, d_q}) begin
            acc_n = diff[DW-1:0];
        end
    end

    // Operand capture, iteration counter and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            q_sh    <= '0;
            d_q     <= '0;
            acc     <= '0;
            iter    <= '0;
            running <= 1'b0;
            rdy     <= 1'b0;
        end else begin
            rdy <= 1'b0;
            if (go && !running) begin
                q_sh    <= dividend;
                d_q     <= divisor;
                acc     <= '0;
                iter    <= CW'(DW);
                running <= 1'b1;
            end else if (running) begin
                acc  <= acc_n;
                q_sh <= {q_sh[DW-2:0], 1'b0};
                iter <= iter - CW'(1);
                if (iter == CW'(1)) begin
                    running <= 1'b0;
                    rdy     <= 1'b1;
                end
            end
        end
    end

    assign rem = acc;

endmodule

// File: rtl/prime_gen.sv
// Streams every prime 2..limit in ascending order, then pulses done with the count.
// Latency: first prime 3 cycles after start; each trial divisor costs DW+2 cycles.
// Backpressure: valid/prime held in EMIT until ready; no skip, no duplicate.
module prime_gen
    import prime_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    output logic             busy,
    output logic [WIDTH-1:0] prime,
    output logic             valid,
    input  logic             ready,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    state_t             state, state_n;
    logic [WIDTH-1:0]   cand, cand_n;
    logic [WIDTH-1:0]   div, div_n;
    logic [WIDTH-1:0]   lim_q, lim_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               pend, pend_n;
    logic               adv;
    logic               rem_go;
    logic               rem_rdy;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] sq;
    logic               cand_last;

    // Full-width square so that e.g. 16*16 cannot wrap to 0
    assign sq        = {{WIDTH{1'b0}}, div} * {{WIDTH{1'b0}}, div};
    assign cand_last = (cand == lim_q) || (cand == MAX_CAND);

    prime_rem #(
        .DW(WIDTH)
    ) u_rem (
        .clk      (clk),
        .rst      (rst),
        .go       (rem_go),
        .dividend (cand),
        .divisor  (div),
        .rdy      (rem_rdy),
        .rem      (rem)
    );

    // Next-state and datapath updates; adv moves to the next candidate or finishes
    always_comb begin
        state_n = state;
        cand_n  = cand;
        div_n   = div;
        lim_n   = lim_q;
        cnt_n   = cnt_q;
        pend_n  = pend;
        rem_go  = 1'b0;
        adv     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    lim_n   = limit;
                    cnt_n   = '0;
                    cand_n  = WIDTH'(2);
                    state_n = INIT;
                end
            end
            INIT: begin
                if (lim_q < WIDTH'(2)) begin
                    state_n = FIN;
                end else begin
                    div_n   = WIDTH'(2);
                    state_n = TEST;
                end
            end
            TEST: begin
                if (!pend) begin
                    if (sq > {{WIDTH{1'b0}}, cand}) begin
                        state_n = EMIT;
                    end else begin
                        rem_go = 1'b1;
                        pend_n = 1'b1;
                    end
                end else if (rem_rdy) begin
                    pend_n = 1'b0;
                    if (rem == '0) begin
                        adv = 1'b1;
                    end else begin
                        div_n = div + WIDTH'(1);
                    end
                end
            end
            EMIT: begin
                if (ready) begin
                    cnt_n = cnt_q + CNT_W'(1);
                    adv   = 1'b1;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (adv) begin
            if (cand_last) begin
                state_n = FIN;
            end else begin
                cand_n  = cand + WIDTH'(1);
                div_n   = WIDTH'(2);
                state_n = TEST;
            end
        end
    end

    // State and datapath registers; reset aborts any run in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cand  <= '0;
            div   <= '0;
            lim_q <= '0;
            cnt_q <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            div   <= div_n;
            lim_q <= lim_n;
            cnt_q <= cnt_n;
            pend  <= pend_n;
        end
    end

    // Outputs decode registered state only
    assign busy  = (state != IDLE);
    assign valid = (state == EMIT);
    assign done  = (state == FIN);
    assign prime = valid ? cand : '0;
    assign count = cnt_q;

endmodule
